// File: rtl/jt900h_muldiv_pkg.sv
// +----------------------------------------------------------------------+
// | jt900h_muldiv_pkg                                                    |
// | Opcode and state encodings for the iterative multiply/divide unit.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package jt900h_muldiv_pkg;

  localparam logic [1:0] MD_MUL  = 2'd0;
  localparam logic [1:0] MD_MULS = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_DIVS = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/jt900h_muldiv_step.sv
// +----------------------------------------------------------------------+
// | jt900h_muldiv_step                                                   |
// | BPC chained MSB-first shift-add / restoring-subtract iterations.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module jt900h_muldiv_step
  import jt900h_muldiv_pkg::*;
#(
  parameter int DW  = 16,
  parameter int BPC = 1
) (
  input  logic              i_div,
  input  logic [DW-1:0]     i_a,
  input  logic [2*DW-1:0]   i_acc,
  input  logic [DW-1:0]     i_sh,
  output logic [2*DW-1:0]   o_acc,
  output logic [DW-1:0]     o_sh
);

  logic [2*DW-1:0] w_acc [BPC+1];
  logic [DW-1:0]   w_sh  [BPC+1];

  assign w_acc[0] = i_acc;
  assign w_sh[0]  = i_sh;

  // Multiply: acc = 2*acc + bit*a. Divide: low DW bits of acc hold the
  // partial remainder, quotient bits enter the shifter at its LSB.
  for (genvar k = 0; k < BPC; k++) begin : g_stage
    logic [DW:0]   w_t;
    logic [DW:0]   w_diff;
    logic          w_ge;
    logic [DW-1:0] w_addend;

    assign w_t      = {w_acc[k][DW-1:0], w_sh[k][DW-1]};
    assign w_diff   = w_t - {1'b0, i_a};
    assign w_ge     = w_t >= {1'b0, i_a};
    assign w_addend = w_sh[k][DW-1] ? i_a : {DW{1'b0}};

    assign w_acc[k+1] = i_div ? {{(DW-1){1'b0}}, (w_ge ? w_diff : w_t)}
                              : {w_acc[k][2*DW-2:0], 1'b0} + {{DW{1'b0}}, w_addend};
    assign w_sh[k+1]  = {w_sh[k][DW-2:0], i_div & w_ge};
  end

  assign o_acc = w_acc[BPC];
  assign o_sh  = w_sh[BPC];

endmodule

`default_nettype wire

// File: rtl/jt900h_muldiv.sv
// +----------------------------------------------------------------------+
// | jt900h_muldiv                                                        |
// | Iterative MUL/MULS/DIV/DIVS unit for the TLCS-900H core.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module jt900h_muldiv
  import jt900h_muldiv_pkg::*;
#(
  parameter int DW  = 16,
  parameter int BPC = 1
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            i_cen,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic            i_wide,
  input  logic [2*DW-1:0] i_op0,
  input  logic [DW-1:0]   i_op1,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*DW-1:0] o_dout,
  output logic            o_v
);

  localparam int HW = DW / 2;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] C_CNT_W = CW'(DW / BPC - 1);
  localparam logic [CW-1:0] C_CNT_H = CW'(HW / BPC - 1);

  function automatic logic [DW-1:0] f_neg1(input logic [DW-1:0] x, input logic wide);
    logic [DW-1:0] n;
    n = -x;
    return wide ? n : {{HW{1'b0}}, n[HW-1:0]};
  endfunction

  function automatic logic [2*DW-1:0] f_neg2(input logic [2*DW-1:0] x, input logic wide);
    logic [2*DW-1:0] n;
    n = -x;
    return wide ? n : {{DW{1'b0}}, n[DW-1:0]};
  endfunction

  md_state_t       r_state, w_next;
  logic [1:0]      r_op;
  logic            r_wide, r_neg, r_rneg, r_big, r_v;
  logic [2*DW-1:0] r_acc, r_op0, r_dout;
  logic [DW-1:0]   r_sh, r_a;
  logic [CW-1:0]   r_cnt;

  // Start-cycle operand conditioning: masking to N, signs, magnitudes
  logic [DW-1:0]   w_a, w_b, w_am, w_bm, w_hi, w_lo;
  logic [2*DW-1:0] w_d, w_dm;
  logic            w_sa, w_sb, w_sd, w_ovf, w_exc;

  assign w_a  = i_wide ? i_op0[DW-1:0] : {{HW{1'b0}}, i_op0[HW-1:0]};
  assign w_b  = i_wide ? i_op1 : {{HW{1'b0}}, i_op1[HW-1:0]};
  assign w_d  = i_wide ? i_op0 : {{DW{1'b0}}, i_op0[DW-1:0]};
  assign w_sa = i_op[0] & (i_wide ? i_op0[DW-1]   : i_op0[HW-1]);
  assign w_sb = i_op[0] & (i_wide ? i_op1[DW-1]   : i_op1[HW-1]);
  assign w_sd = i_op[0] & (i_wide ? i_op0[2*DW-1] : i_op0[DW-1]);
  assign w_am = w_sa ? f_neg1(w_a, i_wide) : w_a;
  assign w_bm = w_sb ? f_neg1(w_b, i_wide) : w_b;
  assign w_dm = w_sd ? f_neg2(w_d, i_wide) : w_d;
  assign w_hi = i_wide ? w_dm[2*DW-1:DW] : {{HW{1'b0}}, w_dm[DW-1:HW]};
  assign w_lo = i_wide ? w_dm[DW-1:0]    : {w_dm[HW-1:0], {HW{1'b0}}};
  assign w_ovf = w_hi >= w_bm;
  assign w_exc = i_op[1] & ((w_b == '0) | (~i_op[0] & w_ovf));

  logic [2*DW-1:0] w_acc_nx;
  logic [DW-1:0]   w_sh_nx;

  jt900h_muldiv_step #(.DW(DW), .BPC(BPC)) u_step (
    .i_div (r_op[1]),
    .i_a   (r_a),
    .i_acc (r_acc),
    .i_sh  (r_sh),
    .o_acc (w_acc_nx),
    .o_sh  (w_sh_nx)
  );

  // Sign fix-up of the unsigned magnitude result
  logic [DW-1:0]   w_qs, w_rs, w_half;
  logic [2*DW-1:0] w_prod, w_divres;
  logic            w_sovf;

  assign w_half   = r_wide ? {1'b1, {(DW-1){1'b0}}} : {{HW{1'b0}}, 1'b1, {(HW-1){1'b0}}};
  assign w_qs     = r_neg  ? f_neg1(r_sh, r_wide) : r_sh;
  assign w_rs     = r_rneg ? f_neg1(r_acc[DW-1:0], r_wide) : r_acc[DW-1:0];
  assign w_prod   = r_neg  ? f_neg2(r_acc, r_wide) : r_acc;
  assign w_divres = r_wide ? {w_rs, w_qs} : {{DW{1'b0}}, w_rs[HW-1:0], w_qs[HW-1:0]};
  assign w_sovf   = r_op[0] & (r_big | (r_sh > w_half) | ((r_sh == w_half) & ~r_neg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else if (i_cen) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_next = w_exc ? MD_DONE : MD_CALC;
      MD_CALC: if (r_cnt == '0) w_next = MD_FIX;
      MD_FIX:  w_next = MD_DONE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_wide <= 1'b0;
      r_acc  <= '0;
      r_sh   <= '0;
      r_a    <= '0;
      r_op0  <= '0;
      r_cnt  <= '0;
      r_neg  <= 1'b0;
      r_rneg <= 1'b0;
      r_big  <= 1'b0;
      r_dout <= '0;
      r_v    <= 1'b0;
    end else if (i_cen) begin
      case (r_state)
        MD_IDLE: if (i_start) begin
          r_op   <= i_op;
          r_wide <= i_wide;
          r_op0  <= w_d;
          r_cnt  <= i_wide ? C_CNT_W : C_CNT_H;
          r_neg  <= (i_op[1] ? w_sd : w_sa) ^ w_sb;
          r_rneg <= w_sd;
          // DIVS whose magnitude quotient needs more than N bits
          r_big  <= i_op[0] & w_ovf;
          if (i_op[1]) begin
            r_acc <= {{DW{1'b0}}, w_hi};
            r_sh  <= w_lo;
            r_a   <= w_bm;
          end else begin
            r_acc <= '0;
            r_sh  <= i_wide ? w_bm : {w_bm[HW-1:0], {HW{1'b0}}};
            r_a   <= w_am;
          end
          if (w_exc) begin
            r_v    <= 1'b1;
            r_dout <= w_d;
          end
        end
        MD_CALC: begin
          r_acc <= w_acc_nx;
          r_sh  <= w_sh_nx;
          r_cnt <= r_cnt - 1'b1;
        end
        MD_FIX: begin
          if (r_op[1]) begin
            r_v    <= w_sovf;
            r_dout <= w_sovf ? r_op0 : w_divres;
          end else begin
            r_v    <= 1'b0;
            r_dout <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != MD_IDLE);
  assign o_done = (r_state == MD_DONE);
  assign o_dout = r_dout;
  assign o_v    = r_v;

endmodule

`default_nettype wire

// File: tb/tb_jt900h_muldiv.sv
// +----------------------------------------------------------------------+
// | tb_jt900h_muldiv                                                     |
// | Scoreboard bench: BPC=1 and BPC=2 instances against an arithmetic    |
// | reference model.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_jt900h_muldiv;

  localparam int DW = 16;

  logic        rst, clk, cen, start1, start2, wide;
  logic [1:0]  op;
  logic [31:0] op0;
  logic [15:0] op1;
  logic        busy1, done1, v1, busy2, done2, v2;
  logic [31:0] dout1, dout2;

  int checks = 0;
  int errors = 0;
  int ec = 0;
  bit cen_toggle = 0;

  typedef struct {
    logic [31:0] dout;
    logic        v;
    int          lat;
    int          e0;
  } exp_t;
  exp_t q1[$], q2[$];

  jt900h_muldiv #(.DW(DW), .BPC(1)) u_dut1 (
    .rst(rst), .clk(clk), .i_cen(cen), .i_start(start1), .i_op(op), .i_wide(wide),
    .i_op0(op0), .i_op1(op1), .o_busy(busy1), .o_done(done1), .o_dout(dout1), .o_v(v1)
  );

  jt900h_muldiv #(.DW(DW), .BPC(2)) u_dut2 (
    .rst(rst), .clk(clk), .i_cen(cen), .i_start(start2), .i_op(op), .i_wide(wide),
    .i_op0(op0), .i_op1(op1), .o_busy(busy2), .o_done(done2), .o_dout(dout2), .o_v(v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (cen) ec <= ec + 1;

  always @(negedge clk) begin
    if (cen_toggle) cen = ~cen;
    else            cen = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on N-bit / 2N-bit values
  function automatic void model(input logic [1:0] o, input logic w, input logic [31:0] a0,
                                input logic [15:0] a1, output logic [31:0] d,
                                output logic v, output bit early);
    longint one, n, m1, m2, ua, ub, ud, sa, sb, sd, q, r;
    one = 1;
    n  = w ? 16 : 8;
    m1 = (one << n) - 1;
    m2 = (one << (2 * n)) - 1;
    ua = longint'(a0) & m1;
    ub = longint'(a1) & m1;
    ud = longint'(a0) & m2;
    sa = ((ua >> (n - 1)) & 1) != 0 ? ua - (one << n) : ua;
    sb = ((ub >> (n - 1)) & 1) != 0 ? ub - (one << n) : ub;
    sd = ((ud >> (2 * n - 1)) & 1) != 0 ? ud - (one << (2 * n)) : ud;
    v = 1'b0;
    early = 0;
    d = '0;
    case (o)
      2'd0: d = 32'((ua * ub) & m2);
      2'd1: d = 32'((sa * sb) & m2);
      2'd2: begin
        if (ub == 0 || ud / ub >= (one << n)) begin
          v = 1'b1; early = 1; d = 32'(ud);
        end else begin
          d = 32'(((ud % ub) << n) | (ud / ub));
        end
      end
      default: begin
        if (ub == 0) begin
          v = 1'b1; early = 1; d = 32'(ud);
        end else begin
          q = sd / sb;
          r = sd % sb;
          if (q > (one << (n - 1)) - 1 || q < -(one << (n - 1))) begin
            v = 1'b1; d = 32'(ud);
          end else begin
            d = 32'(((r & m1) << n) | (q & m1));
          end
        end
      end
    endcase
  endfunction

  task automatic mon(input int id, input logic [31:0] d, input logic v);
    exp_t e;
    string tag;
    tag = (id == 1) ? "bpc1" : "bpc2";
    if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
      checks++; errors++;
      $display("FAIL %s unexpected_done: got done=1 expected no done", tag);
    end else begin
      e = (id == 1) ? q1.pop_front() : q2.pop_front();
      chk({tag, " dout"}, d, e.dout);
      chk({tag, " v"}, 32'(v), 32'(e.v));
      chk({tag, " latency"}, 32'(ec - e.e0 + 1), 32'(e.lat));
    end
  endtask

  logic pd1 = 1'b0, pd2 = 1'b0;
  always @(negedge clk) begin
    if (done1 && !pd1) mon(1, dout1, v1);
    if (done2 && !pd2) mon(2, dout2, v2);
    pd1 = done1;
    pd2 = done2;
  end

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy1 || busy2) && g < 2000);
    if (busy1 || busy2) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%b/%b expected 0/0", busy1, busy2);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic w, input logic [31:0] a0,
                       input logic [15:0] a1);
    exp_t e1, e2;
    logic [31:0] d;
    logic v;
    bit early;
    int g;
    wait_idle();
    @(negedge clk);
    op = o; wide = w; op0 = a0; op1 = a1; start1 = 1'b1; start2 = 1'b1;
    g = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
    end while (!cen && g < 100);
    model(o, w, a0, a1, d, v, early);
    e1.dout = d; e1.v = v; e1.e0 = ec; e2 = e1;
    e1.lat = early ? 1 : (w ? 16 : 8) + 2;
    e2.lat = early ? 1 : (w ? 16 : 8) / 2 + 2;
    q1.push_back(e1);
    q2.push_back(e2);
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    op0 = $urandom; op1 = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; start1 = 1'b0; start2 = 1'b0;
    op = 2'd0; wide = 1'b0; op0 = '0; op1 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'({busy1, busy2}), 32'd0);
    chk("reset done", 32'({done1, done2}), 32'd0);
    chk("reset dout", dout1 | dout2, 32'd0);
    chk("reset v", 32'({v1, v2}), 32'd0);
    rst = 1'b0;

    issue(2'd0, 1'b1, 32'h0000_1234, 16'h0010);
    issue(2'd1, 1'b0, 32'h0000_00FF, 16'h0002);
    issue(2'd2, 1'b0, 32'h0000_0064, 16'h0007);
    issue(2'd3, 1'b1, 32'hFFFF_FFF9, 16'h0002);
    issue(2'd3, 1'b1, 32'h8000_0000, 16'hFFFF);
    issue(2'd3, 1'b1, 32'h0000_0064, 16'hFFFF);
    issue(2'd2, 1'b1, 32'hCAFE_1234, 16'h0000);
    issue(2'd2, 1'b1, 32'h0005_0000, 16'h0004);
    issue(2'd3, 1'b0, 32'h0000_8000, 16'h00FF);
    issue(2'd3, 1'b0, 32'h0000_FF80, 16'h0001);

    // Clock enable toggling every clock during a full-width multiply
    wait_idle();
    cen_toggle = 1;
    issue(2'd0, 1'b1, 32'h0000_ABCD, 16'h1357);
    wait_idle();
    cen_toggle = 0;

    // Start while busy must be ignored
    issue(2'd0, 1'b1, 32'h0000_0101, 16'h0202);
    repeat (3) @(negedge clk);
    op = 2'd2; wide = 1'b0; op0 = 32'h0000_0005; op1 = 16'h0000;
    start1 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;

    // Start coinciding with the done cycle must be ignored
    issue(2'd2, 1'b1, 32'h0012_3456, 16'h0345);
    begin
      int g;
      g = 0;
      while (!done1 && g < 100) begin
        @(negedge clk);
        g++;
      end
    end
    op = 2'd0; wide = 1'b0; op0 = 32'h0000_0003; op1 = 16'h0003; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;

    // Reset in the middle of an operation
    issue(2'd0, 1'b1, 32'h0000_7777, 16'h8888);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'({busy1, busy2}), 32'd0);
    chk("midrst done", 32'({done1, done2}), 32'd0);
    chk("midrst dout", dout1 | dout2, 32'd0);
    q1.delete();
    q2.delete();
    rst = 1'b0;
    issue(2'd1, 1'b1, 32'h0000_8000, 16'h8000);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a0;
      logic [15:0] a1;
      o  = 2'($urandom_range(0, 3));
      a0 = $urandom;
      a1 = 16'($urandom);
      if (o[1] && $urandom_range(0, 1) == 1) a0 = a0 >> $urandom_range(8, 24);
      if (o == 2'd3 && $urandom_range(0, 5) == 0) a1 = 16'hFFFF;
      wait_idle();
      cen_toggle = ($urandom_range(0, 3) == 0);
      issue(o, 1'($urandom_range(0, 1)), a0, a1);
    end
    wait_idle();
    cen_toggle = 0;
    repeat (4) @(negedge clk);
    chk("pending bpc1", 32'(q1.size()), 32'd0);
    chk("pending bpc2", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
